// File: rtl/layer_pkg.sv
// Shared constants and helpers for the per-layer post-accumulation stages:
// sign-magnitude bias decoding and signed 16-bit saturation.
package layer_pkg;

  localparam int BIAS_W        = 16;
  localparam int BIAS_SIGN_BIT = 15;
  localparam int BIAS_MAG_MSB  = 14;
  localparam int BIAS_TC_W     = BIAS_W + 1;
  localparam int OUT_W         = 16;

  // 17 bits so that -32767..+32767 fits; negative zero decodes to plain 0.
  function automatic logic signed [BIAS_TC_W-1:0] sm_to_tc(input logic [BIAS_W-1:0] sm);
    logic signed [BIAS_TC_W-1:0] mag;
    mag = {2'b00, sm[BIAS_MAG_MSB:0]};
    return sm[BIAS_SIGN_BIT] ? -mag : mag;
  endfunction

  function automatic logic [OUT_W-1:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return 16'h7FFF;
    end else if (v < -64'sd32768) begin
      return 16'h8000;
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bias_sat_add.sv
// Combinational rescaled-accumulator plus bias, clamped to signed 16 bits,
// with optional ReLU. Shared by the post-processing stages of every layer.
module bias_sat_add
  import layer_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]     acc_s_i,
  input  logic signed [BIAS_TC_W-1:0] bias_i,
  output logic [OUT_W-1:0]            data_o
);

  logic signed [ACC_W:0] sum;
  logic [OUT_W-1:0]      satVal;

  // One extra bit of headroom means the addition itself can never wrap.
  always_comb begin
    sum    = (ACC_W+1)'(acc_s_i) + (ACC_W+1)'(bias_i);
    satVal = sat16(64'(sum));
    data_o = (RELU_EN && satVal[OUT_W-1]) ? '0 : satVal;
  end

endmodule

// File: rtl/bias_relu_stage.sv
// Two-stage streaming bias/saturate/ReLU stage for one conv layer, tagging
// each accumulator beat with its channel and honouring downstream back-pressure.
module bias_relu_stage
  import layer_pkg::*;
#(
  parameter int NUM_CH  = 128,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 8,
  parameter bit RELU_EN = 1'b1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CH-1:0][BIAS_W-1:0] bias_mem_i,
  input  logic                          clear_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [ACC_W-1:0]              in_acc_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [OUT_W-1:0]              out_data_o,
  output logic [CH_W-1:0]               out_ch_o,
  output logic                          out_ch_last_o
);

  logic [CH_W-1:0] chCnt_q, chCnt_d;
  logic [CH_W-1:0] tagCh;
  logic            accept;
  logic            s1Load;
  logic            s2Load;

  logic                          s1Valid_q, s1Valid_d;
  logic signed [ACC_W-1:0]       s1AccS_q, s1AccS_d;
  logic signed [BIAS_TC_W-1:0]   s1Bias_q, s1Bias_d;
  logic [CH_W-1:0]               s1Ch_q, s1Ch_d;

  logic                          s2Valid_q, s2Valid_d;
  logic [OUT_W-1:0]              s2Data_q, s2Data_d;
  logic [CH_W-1:0]               s2Ch_q, s2Ch_d;
  logic                          s2Last_q, s2Last_d;

  logic [OUT_W-1:0]              sumData;

  assign s2Load     = !s2Valid_q || out_ready_i;
  assign s1Load     = !s1Valid_q || s2Load;
  assign in_ready_o = s1Load;
  assign accept     = in_valid_i && s1Load;

  // clear restarts the frame: a beat accepted alongside it becomes channel 0.
  always_comb begin
    tagCh   = clear_i ? '0 : chCnt_q;
    chCnt_d = chCnt_q;
    if (clear_i) begin
      chCnt_d = accept ? CH_W'(1) : '0;
    end else if (accept) begin
      chCnt_d = (chCnt_q == CH_W'(NUM_CH-1)) ? '0 : chCnt_q + 1'b1;
    end
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1AccS_d  = s1AccS_q;
    s1Bias_d  = s1Bias_q;
    s1Ch_d    = s1Ch_q;
    if (s1Load) begin
      s1Valid_d = accept;
      if (accept) begin
        s1AccS_d = $signed(in_acc_i) >>> SHIFT;
        s1Bias_d = sm_to_tc(bias_mem_i[tagCh]);
        s1Ch_d   = tagCh;
      end
    end
  end

  bias_sat_add #(
    .ACC_W   (ACC_W),
    .RELU_EN (RELU_EN)
  ) u_bias_sat_add (
    .acc_s_i (s1AccS_q),
    .bias_i  (s1Bias_q),
    .data_o  (sumData)
  );

  always_comb begin
    s2Valid_d = s2Valid_q;
    s2Data_d  = s2Data_q;
    s2Ch_d    = s2Ch_q;
    s2Last_d  = s2Last_q;
    if (s2Load) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Data_d = sumData;
        s2Ch_d   = s1Ch_q;
        s2Last_d = (s1Ch_q == CH_W'(NUM_CH-1));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chCnt_q   <= '0;
      s1Valid_q <= 1'b0;
      s1AccS_q  <= '0;
      s1Bias_q  <= '0;
      s1Ch_q    <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Ch_q    <= '0;
      s2Last_q  <= 1'b0;
    end else begin
      chCnt_q   <= chCnt_d;
      s1Valid_q <= s1Valid_d;
      s1AccS_q  <= s1AccS_d;
      s1Bias_q  <= s1Bias_d;
      s1Ch_q    <= s1Ch_d;
      s2Valid_q <= s2Valid_d;
      s2Data_q  <= s2Data_d;
      s2Ch_q    <= s2Ch_d;
      s2Last_q  <= s2Last_d;
    end
  end

  assign out_valid_o   = s2Valid_q;
  assign out_data_o    = s2Data_q;
  assign out_ch_o      = s2Ch_q;
  assign out_ch_last_o = s2Last_q;

endmodule

// File: tb/tb_bias_relu_stage.sv
// Bench for bias_relu_stage: two instances (ReLU on/off) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_bias_relu_stage;

  localparam int NUM_CH = 128;
  localparam int CH_W   = 7;

  logic                   clk;
  logic                   rst;
  logic [NUM_CH-1:0][15:0] biasMem;
  logic                   clear;
  logic                   inValid;
  logic [31:0]            inAcc;
  logic                   outReady;

  logic                   inReady1, inReady0;
  logic                   outValid1, outValid0;
  logic [15:0]            outData1, outData0;
  logic [CH_W-1:0]        outCh1, outCh0;
  logic                   outChLast1, outChLast0;

  bias_relu_stage #(
    .NUM_CH(NUM_CH), .ACC_W(32), .SHIFT(8), .RELU_EN(1'b1)
  ) dutRelu (
    .clk_i(clk), .rst_i(rst), .bias_mem_i(biasMem), .clear_i(clear),
    .in_valid_i(inValid), .in_ready_o(inReady1), .in_acc_i(inAcc),
    .out_valid_o(outValid1), .out_ready_i(outReady), .out_data_o(outData1),
    .out_ch_o(outCh1), .out_ch_last_o(outChLast1)
  );

  bias_relu_stage #(
    .NUM_CH(NUM_CH), .ACC_W(32), .SHIFT(8), .RELU_EN(1'b0)
  ) dutLinear (
    .clk_i(clk), .rst_i(rst), .bias_mem_i(biasMem), .clear_i(clear),
    .in_valid_i(inValid), .in_ready_o(inReady0), .in_acc_i(inAcc),
    .out_valid_o(outValid0), .out_ready_i(outReady), .out_data_o(outData0),
    .out_ch_o(outCh0), .out_ch_last_o(outChLast0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d0;
    int          ch;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          chSeq[$];
  logic [15:0] cap1 [NUM_CH];
  logic [15:0] cap0 [NUM_CH];
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          modelCh = 0;
  int          accCount = 0;
  int          popCount = 0;
  int          lastCount = 0;
  int          firstAccCycle = -1;
  int          firstOutCycle = -1;
  bit          prevStall = 1'b0;
  logic [15:0] prevD1, prevD0;
  logic [CH_W-1:0] prevCh;
  exp_t        e;
  int          tag;
  bit          expValid, expReady;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: arithmetic shift, sign-magnitude bias, wide add, clamp, ReLU.
  function automatic logic [15:0] refOut(input logic [31:0] acc, input logic [15:0] b, input bit relu);
    longint a, bv, s;
    a  = longint'($signed(acc)) >>> 8;
    bv = longint'(b[14:0]);
    if (b[15]) bv = -bv;
    s = a + bv;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[15:0];
  endfunction

  function automatic logic [31:0] randAcc();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 32'h1FFFF) - 32'h10000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FF00;
      default: return 32'h0000_0100;
    endcase
  endfunction

  always @(posedge rst) begin
    q.delete();
    modelCh = 0;
  end

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      checkOutput("rst_out_valid", {31'b0, outValid1}, 32'd0);
      checkOutput("rst_out_data", {16'b0, outData0}, 32'd0);
      checkOutput("rst_out_ch", {25'b0, outCh1}, 32'd0);
      checkOutput("rst_out_ch_last", {31'b0, outChLast1}, 32'd0);
      checkOutput("rst_in_ready", {31'b0, inReady1}, 32'd1);
      prevStall = 1'b0;
    end else begin
      expValid = (q.size() > 0) && (q[0].cyc <= cycle - 2);
      expReady = (q.size() < 2) || outReady;
      checkOutput("out_valid", {31'b0, outValid1}, {31'b0, expValid});
      checkOutput("out_valid_lin", {31'b0, outValid0}, {31'b0, expValid});
      checkOutput("in_ready", {31'b0, inReady1}, {31'b0, expReady});
      checkOutput("in_ready_lin", {31'b0, inReady0}, {31'b0, expReady});
      if (prevStall) begin
        checkOutput("stall_data", {16'b0, outData1}, {16'b0, prevD1});
        checkOutput("stall_data_lin", {16'b0, outData0}, {16'b0, prevD0});
        checkOutput("stall_ch", {25'b0, outCh1}, {25'b0, prevCh});
      end
      if (outValid1 && firstOutCycle < 0) firstOutCycle = cycle;
      if (outValid1 && outReady && q.size() > 0) begin
        e = q.pop_front();
        checkOutput("data_relu", {16'b0, outData1}, {16'b0, e.d1});
        checkOutput("data_lin", {16'b0, outData0}, {16'b0, e.d0});
        checkOutput("out_ch", {25'b0, outCh1}, e.ch);
        checkOutput("out_ch_lin", {25'b0, outCh0}, e.ch);
        checkOutput("out_ch_last", {31'b0, outChLast1}, {31'b0, (e.ch == NUM_CH-1)});
        checkOutput("out_ch_last_lin", {31'b0, outChLast0}, {31'b0, (e.ch == NUM_CH-1)});
        cap1[e.ch] = outData1;
        cap0[e.ch] = outData0;
        popCount++;
        if (outChLast1) lastCount++;
        chSeq.push_back(int'(outCh1));
      end
      prevStall = outValid1 && !outReady;
      prevD1 = outData1;
      prevD0 = outData0;
      prevCh = outCh1;
      if (inValid && inReady1) begin
        tag = clear ? 0 : modelCh;
        e.d1  = refOut(inAcc, biasMem[tag], 1'b1);
        e.d0  = refOut(inAcc, biasMem[tag], 1'b0);
        e.ch  = tag;
        e.cyc = cycle;
        q.push_back(e);
        modelCh = clear ? 1 : (modelCh + 1) % NUM_CH;
        accCount++;
        if (firstAccCycle < 0) firstAccCycle = cycle;
      end else if (clear) begin
        modelCh = 0;
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [31:0] acc, input bit clr, input bit rdy);
    inValid  = v;
    inAcc    = acc;
    clear    = clr;
    outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    inValid  = 1'b0;
    clear    = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int popBefore;
    int accBefore;
    rst = 1'b1;
    inValid = 1'b0; inAcc = '0; clear = 1'b0; outReady = 1'b1;
    for (int i = 0; i < NUM_CH; i++) biasMem[i] = 16'($urandom_range(0, 16'hFFFF));
    biasMem[0]  = 16'h0115;
    biasMem[1]  = 16'h8019;
    biasMem[98] = 16'h0000;
    biasMem[99] = 16'h8000;

    checkOutput("model_ch0", {16'b0, refOut(32'h100, 16'h0115, 1'b1)}, 32'd278);
    checkOutput("model_ch1_relu", {16'b0, refOut(32'h100, 16'h8019, 1'b1)}, 32'd0);
    checkOutput("model_ch1_lin", {16'b0, refOut(32'h100, 16'h8019, 1'b0)}, 32'h0000FFE8);
    checkOutput("model_negzero", {16'b0, refOut(32'hFFFFFF00, 16'h8000, 1'b0)}, 32'h0000FFFF);
    checkOutput("model_satpos", {16'b0, refOut(32'h7FFFFFFF, 16'h0000, 1'b1)}, 32'h00007FFF);
    checkOutput("model_satneg", {16'b0, refOut(32'h80000000, 16'h0000, 1'b0)}, 32'h00008000);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Frame of acc_s = 1 with no back-pressure.
    for (int i = 0; i < NUM_CH; i++) applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    drain();
    checkOutput("frame_pops", popCount, NUM_CH);
    checkOutput("frame_last_pulses", lastCount, 32'd1);
    checkOutput("first_latency", firstOutCycle - firstAccCycle, 32'd2);
    checkOutput("frame_ch0", {16'b0, cap1[0]}, 32'd278);
    checkOutput("frame_ch1_relu", {16'b0, cap1[1]}, 32'd0);
    checkOutput("frame_ch1_lin", {16'b0, cap0[1]}, 32'h0000FFE8);
    checkOutput("frame_ch98", {16'b0, cap1[98]}, 32'd1);

    // acc_s = -1 over a full frame: zero and negative-zero biases.
    for (int i = 0; i < NUM_CH; i++) applyStimulus(1'b1, 32'hFFFF_FF00, 1'b0, 1'b1);
    drain();
    checkOutput("ch98_lin", {16'b0, cap0[98]}, 32'h0000FFFF);
    checkOutput("ch99_lin", {16'b0, cap0[99]}, 32'h0000FFFF);
    checkOutput("ch98_relu", {16'b0, cap1[98]}, 32'd0);
    checkOutput("ch99_relu", {16'b0, cap1[99]}, 32'd0);

    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    drain();
    checkOutput("sat_pos", {16'b0, cap1[0]}, 32'h00007FFF);
    checkOutput("sat_neg_lin", {16'b0, cap0[1]}, 32'h00008000);
    checkOutput("sat_neg_relu", {16'b0, cap1[1]}, 32'd0);

    // Five stalled cycles from an empty pipeline admit exactly two beats.
    accBefore = accCount;
    repeat (5) applyStimulus(1'b1, randAcc(), 1'b0, 1'b0);
    checkOutput("bp_accepts", accCount - accBefore, 32'd2);
    checkOutput("bp_in_ready", {31'b0, inReady1}, 32'd0);
    repeat (6) applyStimulus(1'b1, randAcc(), 1'b0, 1'b1);
    drain();

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    chSeq.delete();
    for (int i = 0; i < 57; i++) applyStimulus(1'b1, randAcc(), 1'b0, 1'b1);
    applyStimulus(1'b1, randAcc(), 1'b1, 1'b1);
    applyStimulus(1'b1, randAcc(), 1'b0, 1'b1);
    drain();
    checkOutput("clear_count", chSeq.size(), 32'd59);
    if (chSeq.size() == 59) begin
      checkOutput("clear_before", chSeq[56], 32'd56);
      checkOutput("clear_tag0", chSeq[57], 32'd0);
      checkOutput("clear_tag1", chSeq[58], 32'd1);
    end

    for (int i = 0; i < 3*NUM_CH; i++)
      applyStimulus($urandom_range(0, 3) != 0, randAcc(), $urandom_range(0, 49) == 0,
                    $urandom_range(0, 2) != 0);
    drain();

    // Fill both stages, then hit reset asynchronously mid-cycle.
    for (int i = 0; i < 10 && inReady1; i++) applyStimulus(1'b1, randAcc(), 1'b0, 1'b0);
    checkOutput("fill_full", {31'b0, inReady1}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, outValid1}, 32'd0);
    checkOutput("async_rst_valid_lin", {31'b0, outValid0}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    popBefore = popCount;
    chSeq.delete();
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    drain();
    checkOutput("post_rst_pops", popCount - popBefore, 32'd1);
    if (chSeq.size() == 1) checkOutput("post_rst_ch", chSeq[0], 32'd0);
    checkOutput("post_rst_data", {16'b0, cap1[0]}, 32'd278);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
